// File: rtl/ga_run_controller_pkg.sv
// Shared types and default widths for the GA engine.
package ga_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SEL    = 3'd2,
    ST_MUT    = 3'd3,
    ST_FINISH = 3'd4
  } ga_state_t;

  localparam int GA_GEN_W = 16;
  localparam int GA_FIT_W = 16;
  localparam int GA_POP_W = 7500;
endpackage

// File: rtl/ga_run_controller_if.sv
// Run-control bus between the sequencer (master) and its environment (slave).
interface ga_run_controller_if
  import ga_pkg::*;
#(
  parameter int GEN_W = GA_GEN_W,
  parameter int FIT_W = GA_FIT_W
);
  logic             start;
  logic             abort;
  logic [GEN_W-1:0] max_gen;
  logic [FIT_W-1:0] target_fit;
  logic             in_done;
  logic             sel_done;
  logic             mut_done;
  logic [FIT_W-1:0] gen_fit;
  logic             in_start;
  logic             sel_start;
  logic             mut_start;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic             hit_target;
  logic [GEN_W-1:0] gen_count;
  logic [FIT_W-1:0] best_fit;
  logic [2:0]       state_out;

  modport master (
    input  start, abort, max_gen, target_fit, in_done, sel_done, mut_done, gen_fit,
    output in_start, sel_start, mut_start, busy, done, timeout_err, hit_target,
           gen_count, best_fit, state_out
  );
  modport slave (
    output start, abort, max_gen, target_fit, in_done, sel_done, mut_done, gen_fit,
    input  in_start, sel_start, mut_start, busy, done, timeout_err, hit_target,
           gen_count, best_fit, state_out
  );
endinterface

// File: rtl/ga_run_controller_edge_rise.sv
// Single-bit rising-edge detector; rise_o is high when d_i is 1 and was 0 last cycle.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);
  logic prev_q;

  // previous-cycle copy of the input, tracked every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;
endmodule

// File: rtl/ga_run_controller.sv
// Run sequencer: INIT -> (SEL -> MUT)* -> FINISH with budget, target, watchdog and abort.
module ga_run_controller
  import ga_pkg::*;
#(
  parameter int GEN_W   = GA_GEN_W,
  parameter int FIT_W   = GA_FIT_W,
  parameter int TIMEOUT = 65535
) (
  input logic                 clk,
  input logic                 rst_n,
  ga_run_controller_if.master bus
);
  // watchdog only needs to count up to TIMEOUT-1
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  ga_state_t        state_q, state_d;
  logic [GEN_W-1:0] gen_q, gen_d, maxg_q, maxg_d, gen_inc;
  logic [FIT_W-1:0] best_q, best_d, tgt_q, tgt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             to_q, to_d, hit_q, hit_d;
  logic             in_st_q, in_st_d, sel_st_q, sel_st_d, mut_st_q, mut_st_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             wd_exp, act_q;
  logic [2:0]       done_vec, rise;

  assign done_vec = {bus.mut_done, bus.sel_done, bus.in_done};

  // one edge detector per stage done; all track regardless of state
  for (genvar i = 0; i < 3; i++) begin : g_edge
    edge_rise u_edge (.clk(clk), .rst_n(rst_n), .d_i(done_vec[i]), .rise_o(rise[i]));
  end

  assign act_q   = (state_q == ST_INIT) || (state_q == ST_SEL) || (state_q == ST_MUT);
  assign wd_exp  = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT - 1));
  assign gen_inc = (gen_q == '1) ? gen_q : gen_q + 1'b1;

  // next-state, counters, flags and start pulses; done edges take priority over the watchdog
  always_comb begin
    state_d  = state_q;
    gen_d    = gen_q;
    best_d   = best_q;
    to_d     = to_q;
    hit_d    = hit_q;
    maxg_d   = maxg_q;
    tgt_d    = tgt_q;
    in_st_d  = 1'b0;
    sel_st_d = 1'b0;
    mut_st_d = 1'b0;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_FINISH: if (bus.start) begin
          state_d = ST_INIT;
          in_st_d = 1'b1;
          gen_d   = '0;
          best_d  = '0;
          to_d    = 1'b0;
          hit_d   = 1'b0;
          maxg_d  = bus.max_gen;
          tgt_d   = bus.target_fit;
        end
        ST_INIT: if (rise[0]) begin
          state_d  = ST_SEL;
          sel_st_d = 1'b1;
        end else if (wd_exp) begin
          state_d = ST_FINISH;
          to_d    = 1'b1;
        end
        ST_SEL: if (rise[1]) begin
          best_d = (bus.gen_fit > best_q) ? bus.gen_fit : best_q;
          if (bus.gen_fit >= tgt_q) begin
            hit_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            state_d  = ST_MUT;
            mut_st_d = 1'b1;
          end
        end else if (wd_exp) begin
          state_d = ST_FINISH;
          to_d    = 1'b1;
        end
        ST_MUT: if (rise[2]) begin
          gen_d = gen_inc;
          if (maxg_q != '0 && gen_inc == maxg_q) begin
            state_d = ST_FINISH;
          end else begin
            state_d  = ST_SEL;
            sel_st_d = 1'b1;
          end
        end else if (wd_exp) begin
          state_d = ST_FINISH;
          to_d    = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    wd_d   = (act_q && state_d == state_q) ? wd_q + WD_W'(1) : '0;
    busy_d = (state_d == ST_INIT) || (state_d == ST_SEL) || (state_d == ST_MUT);
    done_d = (state_d == ST_FINISH);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gen_q    <= '0;
      best_q   <= '0;
      to_q     <= 1'b0;
      hit_q    <= 1'b0;
      maxg_q   <= '0;
      tgt_q    <= '0;
      wd_q     <= '0;
      in_st_q  <= 1'b0;
      sel_st_q <= 1'b0;
      mut_st_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gen_q    <= gen_d;
      best_q   <= best_d;
      to_q     <= to_d;
      hit_q    <= hit_d;
      maxg_q   <= maxg_d;
      tgt_q    <= tgt_d;
      wd_q     <= wd_d;
      in_st_q  <= in_st_d;
      sel_st_q <= sel_st_d;
      mut_st_q <= mut_st_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.in_start    = in_st_q;
  assign bus.sel_start   = sel_st_q;
  assign bus.mut_start   = mut_st_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = to_q;
  assign bus.hit_target  = hit_q;
  assign bus.gen_count   = gen_q;
  assign bus.best_fit    = best_q;
  assign bus.state_out   = state_q;
endmodule
